// File: rtl/udp_tx_pkg.sv
// Shared types and helpers for the UDP TX arbiter: status word width, status field offsets, FSM states.
package udp_tx_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_CLOSE = 2'd2
  } arb_state_e;

  // status = {len[2*BYTE_SIZE], ip[IP_SIZE], mac[MAC_SIZE]}
  function automatic int sw_width(input int byte_size, input int ip_size, input int mac_size);
    return 2*byte_size + ip_size + mac_size;
  endfunction

  function automatic int len_lsb(input int ip_size, input int mac_size);
    return ip_size + mac_size;
  endfunction

  function automatic int ip_lsb(input int mac_size);
    return mac_size;
  endfunction

  localparam int MAC_LSB = 0;

endpackage

// File: rtl/udp_tx_arbiter_rr.sv
// Combinational round-robin pick: lowest requesting index at or above ptr, wrapping.
module rr_arbiter #(
  parameter  int N_SRC = 2,
  localparam int PW    = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic [N_SRC-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_SRC-1:0] grant,
  output logic [PW-1:0]    idx,
  output logic             found
);

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      if (!found && req[(int'(ptr) + k) % N_SRC]) begin
        found                          = 1'b1;
        grant[(int'(ptr) + k) % N_SRC] = 1'b1;
        idx                            = PW'((int'(ptr) + k) % N_SRC);
      end
    end
  end

endmodule

// File: rtl/udp_tx_arbiter.sv
// Round-robin owner of the shared UDP TX FIFO pair; grant held for one packet (bytes, then status).
// Optional ARB_TIMEOUT_EN: force-close a stalled packet after TIMEOUT_CYCLES idle cycles.
module udp_tx_arbiter
  import udp_tx_pkg::*;
#(
  parameter  int N_SRC          = 2,
  parameter  int AVL_SIZE       = 8,
  parameter  int BYTE_SIZE      = 8,
  parameter  int IP_SIZE        = 32,
  parameter  int MAC_SIZE       = 48,
  parameter  int TIMEOUT_CYCLES = 4096,
  localparam int SW             = sw_width(BYTE_SIZE, IP_SIZE, MAC_SIZE)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_SRC-1:0]          src_req,
  output logic [N_SRC-1:0]          src_grant,
  input  logic [N_SRC*AVL_SIZE-1:0] src_data,
  input  logic [N_SRC-1:0]          src_data_write,
  input  logic [N_SRC*SW-1:0]       src_status,
  input  logic [N_SRC-1:0]          src_status_write,
  output logic [N_SRC-1:0]          src_data_full,
  output logic [N_SRC-1:0]          src_status_full,
  output logic [AVL_SIZE-1:0]       tx_fifo_data,
  output logic [SW-1:0]             tx_fifo_status,
  output logic                      tx_fifo_data_write,
  output logic                      tx_fifo_status_write,
  input  logic                      tx_fifo_data_full,
  input  logic                      tx_fifo_status_full,
  input  logic [MAC_SIZE-1:0]       destination_mac,
  input  logic [IP_SIZE-1:0]        destination_ip,
  output logic                      len_err,
  output logic                      drop_err
);

  localparam int PW     = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int LW     = 2*BYTE_SIZE;
  localparam int LEN_LO = len_lsb(IP_SIZE, MAC_SIZE);

  arb_state_e         state, state_nxt;
  logic [N_SRC-1:0]   grant_q, arb_gnt;
  logic [PW-1:0]      rr_ptr, sel, arb_idx;
  logic               arb_found;
  logic [LW-1:0]      byte_cnt, cnt_next;
  logic               st_pend;
  logic               open, d_strobe, s_strobe, d_acc, s_acc;
  logic [AVL_SIZE-1:0] sel_data;
  logic [SW-1:0]      sel_status;
  logic               tout_wr, tout_close;

  rr_arbiter #(.N_SRC(N_SRC)) u_rr (
    .req   (src_req),
    .ptr   (rr_ptr),
    .grant (arb_gnt),
    .idx   (arb_idx),
    .found (arb_found)
  );

  // open = owner may still push; closes once status is taken until CLOSE
  assign open       = (state == S_GRANT) && !st_pend && !tx_fifo_status_write;
  assign sel_data   = src_data[int'(sel)*AVL_SIZE +: AVL_SIZE];
  assign sel_status = src_status[int'(sel)*SW +: SW];
  assign d_strobe   = src_data_write[sel];
  assign s_strobe   = src_status_write[sel];
  assign d_acc      = open && d_strobe && !tx_fifo_data_full;
  assign s_acc      = open && s_strobe && !tx_fifo_status_full;
  assign cnt_next   = byte_cnt + LW'(d_acc && !(&byte_cnt));

  for (genvar i = 0; i < N_SRC; i++) begin : g_full
    assign src_data_full[i]   = !(grant_q[i] && open) || tx_fifo_data_full;
    assign src_status_full[i] = !(grant_q[i] && open) || tx_fifo_status_full;
  end

  assign src_grant = grant_q;

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_cnt;
  logic          tout;

  assign tout       = open && !(d_strobe || s_strobe) && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign tout_wr    = tout && (byte_cnt != '0) && !tx_fifo_status_full;
  assign tout_close = tout && (byte_cnt == '0);

  always_ff @(posedge clk) begin
    if (reset || !open || d_strobe || s_strobe) idle_cnt <= '0;
    else if (!tout)                             idle_cnt <= idle_cnt + 1'b1;
  end
`else
  logic unused_tout;
  assign unused_tout = ^{destination_ip, destination_mac} ^ TIMEOUT_CYCLES[0];
  assign tout_wr     = 1'b0;
  assign tout_close  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (arb_found) state_nxt = S_GRANT;
      S_GRANT: if (tx_fifo_status_write || tout_close) state_nxt = S_CLOSE;
      S_CLOSE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_q              <= '0;
      sel                  <= '0;
      rr_ptr               <= '0;
      byte_cnt             <= '0;
      st_pend              <= 1'b0;
      tx_fifo_data         <= '0;
      tx_fifo_data_write   <= 1'b0;
      tx_fifo_status       <= '0;
      tx_fifo_status_write <= 1'b0;
      len_err              <= 1'b0;
      drop_err             <= 1'b0;
    end else begin
      if (state == S_IDLE && arb_found) begin
        grant_q <= arb_gnt;
        sel     <= arb_idx;
        rr_ptr  <= (int'(arb_idx) == N_SRC - 1) ? '0 : arb_idx + 1'b1;
      end else if (state == S_GRANT && state_nxt == S_CLOSE) begin
        grant_q <= '0;
      end

      if (state == S_CLOSE) byte_cnt <= '0;
      else                  byte_cnt <= cnt_next;

      tx_fifo_data_write <= d_acc;
      if (d_acc) tx_fifo_data <= sel_data;

      // status taken with a byte in the same cycle goes out one cycle behind it
      tx_fifo_status_write <= 1'b0;
      if (s_acc) begin
        tx_fifo_status <= sel_status;
        if (d_acc) st_pend              <= 1'b1;
        else       tx_fifo_status_write <= 1'b1;
        if (sel_status[LEN_LO +: LW] != cnt_next) len_err <= 1'b1;
      end
      if (st_pend) begin
        st_pend              <= 1'b0;
        tx_fifo_status_write <= 1'b1;
      end
      if (tout_wr) begin
        tx_fifo_status       <= {byte_cnt, destination_ip, destination_mac};
        tx_fifo_status_write <= 1'b1;
      end
      if (tout_wr || tout_close) len_err <= 1'b1;

      if (|(src_data_write & src_data_full) || |(src_status_write & src_status_full))
        drop_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Directed bench for udp_tx_arbiter (N_SRC=2, TIMEOUT_CYCLES=16; timeout case under ARB_TIMEOUT_EN).
module tb_udp_tx_arbiter;

  localparam int N   = 2;
  localparam int AVL = 8;
  localparam int SW  = 96;
  localparam logic [31:0] SRC_IP  = 32'hC0A8_0001;
  localparam logic [47:0] SRC_MAC = 48'h0011_2233_4455;
  localparam logic [31:0] DST_IP  = 32'h0A00_0002;
  localparam logic [47:0] DST_MAC = 48'hAABB_CCDD_EEFF;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    src_req, src_grant, src_data_write, src_status_write;
  logic [N-1:0]    src_data_full, src_status_full;
  logic [N*AVL-1:0] src_data;
  logic [N*SW-1:0] src_status;
  logic [AVL-1:0]  tx_fifo_data;
  logic [SW-1:0]   tx_fifo_status;
  logic            tx_fifo_data_write, tx_fifo_status_write;
  logic            tx_fifo_data_full, tx_fifo_status_full;
  logic            len_err, drop_err;

  int errors = 0;
  int checks = 0;

  always #4 clk = ~clk;

  udp_tx_arbiter #(.N_SRC(N), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .src_req(src_req), .src_grant(src_grant),
    .src_data(src_data), .src_data_write(src_data_write),
    .src_status(src_status), .src_status_write(src_status_write),
    .src_data_full(src_data_full), .src_status_full(src_status_full),
    .tx_fifo_data(tx_fifo_data), .tx_fifo_status(tx_fifo_status),
    .tx_fifo_data_write(tx_fifo_data_write), .tx_fifo_status_write(tx_fifo_status_write),
    .tx_fifo_data_full(tx_fifo_data_full), .tx_fifo_status_full(tx_fifo_status_full),
    .destination_mac(DST_MAC), .destination_ip(DST_IP),
    .len_err(len_err), .drop_err(drop_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    src_req = '0; src_data = '0; src_data_write = '0;
    src_status = '0; src_status_write = '0;
    tx_fifo_data_full = 1'b0; tx_fifo_status_full = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_in();
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic wait_grant(input int s);
    int n = 0;
    do begin tick(); n++; end while (src_grant === '0 && n < 8);
    checks++;
    if (src_grant !== 2'(1 << s)) begin
      errors++; $display("FAIL grant_src%0d: got %b want %b", s, src_grant, 2'(1 << s));
    end
  endtask

  // drive n bytes (base + k*step) then a status with length field len; checks tx side each cycle
  task automatic drive_pkt(input int s, input int n, input logic [15:0] len,
                           input logic [7:0] base, input logic [7:0] step);
    logic [7:0]    e;
    logic [SW-1:0] st;
    for (int k = 0; k < n; k++) begin
      e = base + 8'(k) * step;
      src_data[AVL*s +: AVL] = e;
      src_data_write = 2'(1 << s);
      tick();
      checks++;
      if (tx_fifo_data_write !== 1'b1 || tx_fifo_data !== e) begin
        errors++; $display("FAIL data_src%0d_b%0d: got wr=%b %h want wr=1 %h", s, k, tx_fifo_data_write, tx_fifo_data, e);
      end
    end
    src_data_write = '0;
    st = {len, SRC_IP, SRC_MAC};
    src_status[SW*s +: SW] = st;
    src_status_write = 2'(1 << s);
    tick();
    src_status_write = '0;
    checks++;
    if (tx_fifo_status_write !== 1'b1 || tx_fifo_status !== st || tx_fifo_data_write !== 1'b0) begin
      errors++; $display("FAIL status_src%0d: got swr=%b dwr=%b %h want swr=1 dwr=0 %h", s, tx_fifo_status_write, tx_fifo_data_write, tx_fifo_status, st);
    end
    tick();
    checks++;
    if (src_grant !== '0 || tx_fifo_status_write !== 1'b0) begin
      errors++; $display("FAIL close_src%0d: got grant=%b swr=%b want 00 0", s, src_grant, tx_fifo_status_write);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_in();
    tick(); tick();
    checks++;
    if (src_grant !== '0 || src_data_full !== 2'b11 || src_status_full !== 2'b11) begin
      errors++; $display("FAIL reset_ctrl: got grant=%b dfull=%b sfull=%b want 00 11 11", src_grant, src_data_full, src_status_full);
    end
    checks++;
    if (tx_fifo_data_write !== 1'b0 || tx_fifo_status_write !== 1'b0 || tx_fifo_data !== '0 || tx_fifo_status !== '0) begin
      errors++; $display("FAIL reset_tx: got dwr=%b swr=%b d=%h want all 0", tx_fifo_data_write, tx_fifo_status_write, tx_fifo_data);
    end
    checks++;
    if (len_err !== 1'b0 || drop_err !== 1'b0) begin
      errors++; $display("FAIL reset_err: got len=%b drop=%b want 0 0", len_err, drop_err);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (src_grant !== '0) begin
      errors++; $display("FAIL idle_no_req: got grant=%b want 00", src_grant);
    end
  endtask

  task automatic test_single();
    do_reset();
    src_req = 2'b01;
    wait_grant(0);
    src_req = '0;
    checks++;
    if (src_data_full !== 2'b10 || src_status_full !== 2'b10) begin
      errors++; $display("FAIL single_full: got d=%b s=%b want 10 10", src_data_full, src_status_full);
    end
    drive_pkt(0, 4, 16'd4, 8'h11, 8'h11);
    checks++;
    if (len_err !== 1'b0 || drop_err !== 1'b0) begin
      errors++; $display("FAIL single_err: got len=%b drop=%b want 0 0", len_err, drop_err);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    src_req = 2'b11;
    for (int g = 0; g < 4; g++) begin
      wait_grant(g % 2);
      drive_pkt(g % 2, 1, 16'd1, 8'h50 + 8'(g), 8'h01);
    end
    src_req = '0;
  endtask

  task automatic test_full_stall();
    do_reset();
    src_req = 2'b01;
    wait_grant(0);
    src_req = '0;
    src_data[7:0] = 8'h11; src_data_write = 2'b01;
    tick();
    src_data_write = '0;
    tx_fifo_data_full = 1'b1;
    #1;
    checks++;
    if (src_data_full !== 2'b11) begin
      errors++; $display("FAIL stall_full: got %b want 11", src_data_full);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (tx_fifo_data_write !== 1'b0) begin
        errors++; $display("FAIL stall_nowrite%0d: got %b want 0", k, tx_fifo_data_write);
      end
    end
    tx_fifo_data_full = 1'b0;
    #1;
    checks++;
    if (src_data_full !== 2'b10) begin
      errors++; $display("FAIL stall_release: got %b want 10", src_data_full);
    end
    drive_pkt(0, 2, 16'd3, 8'h22, 8'h11);
    checks++;
    if (len_err !== 1'b0 || drop_err !== 1'b0) begin
      errors++; $display("FAIL stall_err: got len=%b drop=%b want 0 0", len_err, drop_err);
    end
  endtask

  task automatic test_len_err();
    do_reset();
    src_req = 2'b01;
    wait_grant(0);
    src_req = '0;
    drive_pkt(0, 4, 16'd5, 8'h11, 8'h11);
    checks++;
    if (len_err !== 1'b1) begin
      errors++; $display("FAIL len_err_set: got %b want 1", len_err);
    end
    src_req = 2'b10;
    wait_grant(1);
    src_req = '0;
    drive_pkt(1, 2, 16'd2, 8'hA0, 8'h01);
    checks++;
    if (len_err !== 1'b1) begin
      errors++; $display("FAIL len_err_sticky: got %b want 1", len_err);
    end
    do_reset();
    checks++;
    if (len_err !== 1'b0) begin
      errors++; $display("FAIL len_err_clear: got %b want 0", len_err);
    end
  endtask

  task automatic test_drop_and_abort();
    do_reset();
    src_req = 2'b01;
    wait_grant(0);
    src_req = '0;
    src_data[15:8] = 8'h99; src_data_write = 2'b10;
    tick();
    src_data_write = '0;
    checks++;
    if (tx_fifo_data_write !== 1'b0 || drop_err !== 1'b1) begin
      errors++; $display("FAIL drop_ungranted: got wr=%b drop=%b want 0 1", tx_fifo_data_write, drop_err);
    end
    src_data[7:0] = 8'h77; src_data_write = 2'b01;
    tick();
    checks++;
    if (tx_fifo_data_write !== 1'b1 || tx_fifo_data !== 8'h77) begin
      errors++; $display("FAIL abort_pre: got wr=%b %h want 1 77", tx_fifo_data_write, tx_fifo_data);
    end
    reset = 1'b1;
    src_data_write = '0;
    tick();
    checks++;
    if (src_grant !== '0 || tx_fifo_data_write !== 1'b0 || tx_fifo_data !== '0 || drop_err !== 1'b0 || src_data_full !== 2'b11) begin
      errors++; $display("FAIL abort_reset: got grant=%b wr=%b d=%h drop=%b full=%b want 00 0 00 0 11", src_grant, tx_fifo_data_write, tx_fifo_data, drop_err, src_data_full);
    end
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [SW-1:0] st;
    do_reset();
    src_req = 2'b01;
    wait_grant(0);
    src_req = '0;
    st = {16'd1, SRC_IP, SRC_MAC};
    src_data[7:0] = 8'hAA; src_data_write = 2'b01;
    src_status[SW-1:0] = st; src_status_write = 2'b01;
    tick();
    src_data_write = '0; src_status_write = '0;
    checks++;
    if (tx_fifo_data_write !== 1'b1 || tx_fifo_data !== 8'hAA || tx_fifo_status_write !== 1'b0 || src_data_full[0] !== 1'b1) begin
      errors++; $display("FAIL simul_data: got dwr=%b d=%h swr=%b full0=%b want 1 aa 0 1", tx_fifo_data_write, tx_fifo_data, tx_fifo_status_write, src_data_full[0]);
    end
    tick();
    checks++;
    if (tx_fifo_status_write !== 1'b1 || tx_fifo_status !== st || tx_fifo_data_write !== 1'b0) begin
      errors++; $display("FAIL simul_status: got swr=%b dwr=%b %h want 1 0 %h", tx_fifo_status_write, tx_fifo_data_write, tx_fifo_status, st);
    end
    tick();
    checks++;
    if (src_grant !== '0 || len_err !== 1'b0 || drop_err !== 1'b0) begin
      errors++; $display("FAIL simul_close: got grant=%b len=%b drop=%b want 00 0 0", src_grant, len_err, drop_err);
    end
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    int n = 0;
    do_reset();
    src_req = 2'b01;
    wait_grant(0);
    src_req = '0;
    for (int k = 0; k < 3; k++) begin
      src_data[7:0] = 8'h31 + 8'(k); src_data_write = 2'b01;
      tick();
    end
    src_data_write = '0;
    do begin tick(); n++; end while (tx_fifo_status_write !== 1'b1 && n < 40);
    checks++;
    if (n !== 16 || tx_fifo_status !== {16'd3, DST_IP, DST_MAC}) begin
      errors++; $display("FAIL timeout_status: got after %0d cycles %h want 16 %h", n, tx_fifo_status, {16'd3, DST_IP, DST_MAC});
    end
    tick();
    checks++;
    if (src_grant !== '0 || len_err !== 1'b1) begin
      errors++; $display("FAIL timeout_close: got grant=%b len=%b want 00 1", src_grant, len_err);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    clear_in();
    test_reset();
    test_single();
    test_round_robin();
    test_full_stall();
    test_len_err();
    test_drop_and_abort();
    test_back_to_back();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
